// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch front end: PC, IRAM address, one-entry stall hold buffer
// Optional perf counters are compiled in with `define PC_FETCH_PERF_EN.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CTRL_W   = 3,
  parameter logic [CTRL_W-1:0] CTRL_STATE_Default = 3'd0,
  parameter logic [CTRL_W-1:0] CTRL_STATE_Stalled = 3'd1,
  parameter logic [CTRL_W-1:0] CTRL_STATE_Branch  = 3'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_signal_pc_i,
  input  logic              ctrl_iram_rdata_sel_i,
  input  logic              ctrl_to_pc_branch_flag_i,
  input  logic [31:0]       ctrl_to_pc_new_i,
  input  logic [31:0]       iram_rdata_i,
  output logic [31:0]       iram_addr_o,
  output logic              iram_ce_o,
  output logic [31:0]       if_pc_o,
  output logic [31:0]       if_inst_o,
  output logic              if_valid_o
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [15:0]       perf_redirect_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_HOLD     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] fpc_q;
  logic [31:0] hold_q;
  logic        fvalid_q;
  logic        do_branch;
  logic        do_advance;
  logic        squash;

  assign do_branch  = (ctrl_signal_pc_i == CTRL_STATE_Branch) && ctrl_to_pc_branch_flag_i;
  assign do_advance = (ctrl_signal_pc_i == CTRL_STATE_Default);

  // Branch with no flag, Bubble and unknown codes all fall through to the stall arm.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      fpc_q    <= RESET_PC;
      hold_q   <= 32'h0;
      fvalid_q <= 1'b0;
    end else if (do_branch) begin
      state_q  <= ST_REDIRECT;
      pc_q     <= {ctrl_to_pc_new_i[31:2], 2'b00};
      fvalid_q <= 1'b0;
    end else if (do_advance) begin
      state_q  <= ST_FETCH;
      pc_q     <= pc_q + 32'd4;
      fpc_q    <= pc_q;
      fvalid_q <= 1'b1;
    end else if (state_q == ST_FETCH) begin
      // Only the first stalled cycle captures; IRAM has already moved on to pc_q after it.
      state_q <= ST_HOLD;
      hold_q  <= iram_rdata_i;
    end
  end

  assign squash      = ctrl_iram_rdata_sel_i || !fvalid_q;
  assign iram_addr_o = pc_q;
  assign iram_ce_o   = rst;
  assign if_pc_o     = fpc_q;
  assign if_valid_o  = !squash;

  always_comb begin
    if_inst_o = iram_rdata_i;
    if (squash)
      if_inst_o = NOP_INST;
    else if (state_q == ST_HOLD)
      if_inst_o = hold_q;
  end

`ifdef PC_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [15:0] redirect_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q    <= 32'h0;
      redirect_cnt_q <= 16'h0;
    end else begin
      if (if_valid_o && do_advance)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (do_branch)
        redirect_cnt_q <= redirect_cnt_q + 16'd1;
    end
  end

  assign perf_fetch_cnt_o    = fetch_cnt_q;
  assign perf_redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - randomized scoreboard bench for pc_fetch against a consumed-stream model
module tb_pc_fetch;

  localparam logic [2:0]  DEF = 3'd0;
  localparam logic [2:0]  STL = 3'd1;
  localparam logic [2:0]  BR  = 3'd2;
  localparam logic [2:0]  BUB = 3'd3;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic [2:0]  code = DEF;
  logic        sel = 1'b0;
  logic        flag = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic [31:0] rdata;
  logic [31:0] iram_addr, if_pc, if_inst;
  logic        iram_ce, if_valid;

  logic        rst2 = 1'b0;
  logic [31:0] rdata2;
  logic [31:0] iram_addr2, if_pc2, if_inst2;
  logic        iram_ce2, if_valid2;

`ifdef PC_FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_fetch2;
  logic [15:0] perf_red, perf_red2;
`endif

  pc_fetch u_dut (
    .clk(clk), .rst(rst), .ctrl_signal_pc_i(code), .ctrl_iram_rdata_sel_i(sel),
    .ctrl_to_pc_branch_flag_i(flag), .ctrl_to_pc_new_i(tgt), .iram_rdata_i(rdata),
    .iram_addr_o(iram_addr), .iram_ce_o(iram_ce), .if_pc_o(if_pc),
    .if_inst_o(if_inst), .if_valid_o(if_valid)
`ifdef PC_FETCH_PERF_EN
    , .perf_fetch_cnt_o(perf_fetch), .perf_redirect_cnt_o(perf_red)
`endif
  );

  pc_fetch #(.RESET_PC(RPC2)) u_wrap (
    .clk(clk), .rst(rst2), .ctrl_signal_pc_i(DEF), .ctrl_iram_rdata_sel_i(1'b0),
    .ctrl_to_pc_branch_flag_i(1'b0), .ctrl_to_pc_new_i(32'h0), .iram_rdata_i(rdata2),
    .iram_addr_o(iram_addr2), .iram_ce_o(iram_ce2), .if_pc_o(if_pc2),
    .if_inst_o(if_inst2), .if_valid_o(if_valid2)
`ifdef PC_FETCH_PERF_EN
    , .perf_fetch_cnt_o(perf_fetch2), .perf_redirect_cnt_o(perf_red2)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3c5a_96e1;
  endfunction

  always @(posedge clk) rdata  <= mem_word(iram_addr);
  always @(posedge clk) rdata2 <= mem_word(iram_addr2);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   checking = 1'b0;

  // model: next address to fetch, and the instruction currently offered downstream
  logic [31:0] m_pc = RPC;
  logic [31:0] m_pend_pc = RPC;
  bit          m_pend = 1'b0;
  int unsigned m_fetch_cnt = 0;
  int unsigned m_red_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      if (if_valid === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid actual_pc=%h required=no_valid_output", if_pc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (if_pc !== e.pc || if_inst !== e.inst) begin
            bad++;
            $display("FAIL fetch_out actual=%h/%h required=%h/%h", if_pc, if_inst, e.pc, e.inst);
          end
        end
      end else begin
        chk("squash_nop", if_inst, NOP);
      end
    end
  end

  task automatic step(input logic r, input logic [2:0] c, input logic s,
                      input logic f, input logic [31:0] t);
    rst = r; code = c; sel = s; flag = f; tgt = t;
    #1;
    if (checking) begin
      chk("iram_addr", iram_addr, m_pc);
      chk("iram_ce", {31'h0, iram_ce}, {31'h0, r});
      if (m_pend && !s) q.push_back('{pc: m_pend_pc, inst: mem_word(m_pend_pc)});
    end
    if (!r) begin
      m_pc = RPC; m_pend = 1'b0; m_fetch_cnt = 0; m_red_cnt = 0;
    end else if (c == BR && f) begin
      m_pc = {t[31:2], 2'b00}; m_pend = 1'b0; m_red_cnt++;
    end else if (c == DEF) begin
      if (m_pend && !s) m_fetch_cnt++;
      m_pend_pc = m_pc; m_pend = 1'b1; m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(0, DEF, 0, 0, 0);
    checking = 1'b1;
    step(0, BR, 0, 1, 32'h40);
    chk("reset_if_pc", if_pc, RPC);
    chk("reset_valid", {31'h0, if_valid}, 32'h0);

    // wrap instance leaves reset together with the main run
    rst2 = 1'b1;
    #1;
    chk("wrap_addr0", iram_addr2, 32'hFFFF_FFF8);
    step(1, DEF, 0, 0, 0);
    chk("wrap_addr1", iram_addr2, 32'hFFFF_FFFC);
    chk("wrap_valid1", {31'h0, if_valid2}, 32'h1);
    step(1, DEF, 0, 0, 0);
    chk("wrap_addr2", iram_addr2, 32'h0000_0000);
    chk("wrap_pc2", if_pc2, 32'hFFFF_FFFC);
    chk("wrap_inst2", if_inst2, mem_word(32'hFFFF_FFFC));

    // main DUT: now offering pc 4; one more Default puts pc 8 on the output
    step(1, DEF, 0, 0, 0);
    chk("pc_before_stall", if_pc, 32'h8);
    for (int i = 0; i < 3; i++) step(1, STL, 0, 0, 0);
    step(1, DEF, 0, 0, 0);
    step(1, DEF, 0, 0, 0);

    step(1, BR, 1, 1, 32'h0000_0102);
    chk("redirect_addr", iram_addr, 32'h100);
    step(1, DEF, 1, 0, 0);
    chk("redirect_pc", if_pc, 32'h100);
    step(1, DEF, 0, 0, 0);
    step(1, BUB, 0, 0, 0);
    step(1, DEF, 0, 0, 0);
    step(1, DEF, 0, 0, 0);

    step(1, STL, 0, 0, 0);
    step(1, STL, 0, 0, 0);
    step(0, BR, 0, 1, 32'h0000_0500);
    chk("rst_hold_pc", if_pc, RPC);
    chk("rst_hold_valid", {31'h0, if_valid}, 32'h0);
`ifdef PC_FETCH_PERF_EN
    chk("perf_fetch_rst", perf_fetch, 32'h0);
    chk("perf_red_rst", {16'h0, perf_red}, 32'h0);
`endif

    for (int i = 0; i < 500; i++) begin
      int unsigned roll;
      logic [2:0]  c;
      roll = $urandom_range(0, 99);
      if (roll < 50)      c = DEF;
      else if (roll < 70) c = STL;
      else if (roll < 85) c = BR;
      else if (roll < 95) c = BUB;
      else                c = 3'($urandom_range(4, 7));
      step(($urandom_range(0, 99) != 0), c, ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 9) < 8), $urandom);
    end
    step(1, DEF, 0, 0, 0);
    checking = 1'b0;

    chk("queue_drained", q.size(), 32'h0);
`ifdef PC_FETCH_PERF_EN
    chk("perf_fetch_end", perf_fetch, m_fetch_cnt);
    chk("perf_red_end", {16'h0, perf_red}, {16'h0, m_red_cnt[15:0]});
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch front end: owns the program counter, drives the instruction RAM address, and delivers `{pc, instruction, valid}` toward the IF/ID pipeline register. It sits directly downstream of the pipeline controller and consumes the controller's PC control code, redirect flag/target and IRAM read-data select. A one-entry hold buffer preserves the fetched instruction across stalls, so no instruction is lost or duplicated while the PC is frozen.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset.
- `NOP_INST`, 32'h0000_0013, instruction emitted when output is squashed (`addi x0,x0,0`).
- `clk` in 1: sole clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `ctrl_signal_pc_i` in `CTRL_Wire_Bus`: PC control code (`CTRL_STATE_Default` / `CTRL_STATE_Stalled` / `CTRL_STATE_Branch`).
- `ctrl_iram_rdata_sel_i` in 1: 1 = squash fetch output to `NOP_INST`.
- `ctrl_to_pc_branch_flag_i` in 1: redirect target valid.
- `ctrl_to_pc_new_i` in `AddrBus` (32): redirect target.
- `iram_rdata_i` in 32: IRAM read data, synchronous, one cycle after address.
- `iram_addr_o` out 32: IRAM address (= `pc_q`, combinational).
- `iram_ce_o` out 1: IRAM enable.
- `if_pc_o` out 32: PC of instruction on `if_inst_o`.
- `if_inst_o` out 32: fetched instruction.
- `if_valid_o` out 1: `if_inst_o` is a real instruction.
- `perf_fetch_cnt_o` out 32, `perf_redirect_cnt_o` out 16: present only with `PC_FETCH_PERF_EN`.

## Operation
- Registers: `pc_q` (address being fetched), `fpc_q` (address whose data is on `iram_rdata_i`), `hold_q` (32b), `fvalid_q`, state.
- States: FETCH, HOLD, REDIRECT. Per-cycle action by `ctrl_signal_pc_i`:
  - Default: `pc_q <= pc_q+4`, `fpc_q <= pc_q`, `fvalid_q <= 1`; HOLD/REDIRECT -> FETCH.
  - Stalled: `pc_q`, `fpc_q` hold. FETCH -> HOLD, capturing `hold_q <= iram_rdata_i`. HOLD stays HOLD (no recapture). REDIRECT stays REDIRECT.
  - Branch with `ctrl_to_pc_branch_flag_i`=1: `pc_q <= {ctrl_to_pc_new_i[31:2],2'b00}`, `fvalid_q <= 0`; any state -> REDIRECT. Branch with flag=0 treated as Stalled.
  - Any other code (e.g. Bubble): treated as Stalled.
- Output mux: `if_inst_o` = `NOP_INST` if `ctrl_iram_rdata_sel_i` or !`fvalid_q`; else `hold_q` in HOLD; else `iram_rdata_i`. `if_valid_o` = 0 in the squash cases, else 1. `if_pc_o` = `fpc_q`.
- On HOLD -> FETCH, the release cycle outputs `hold_q`; next cycle outputs IRAM data for the old `pc_q`. Sequence is gap-free and duplicate-free.
- Arithmetic: PC increment is modulo 2^32 (32'hFFFF_FFFC + 4 = 0). Target bits [1:0] are forced to 0.
- `iram_ce_o` = 0 while `rst`=0, else 1.

## Timing
- Reset (`rst`=0 at edge): `pc_q`=`fpc_q`=`RESET_PC`, `hold_q`=0, `fvalid_q`=0, state FETCH, counters 0. Outputs: `if_inst_o`=`NOP_INST`, `if_valid_o`=0, `if_pc_o`=`RESET_PC`, `iram_addr_o`=`RESET_PC`.
- Reset wins over every control input in the same cycle. Reset mid-HOLD/REDIRECT discards the buffer and target.
- First valid output: second cycle after reset release (address cycle, then data cycle).
- Redirect latency: Branch cycle loads target; next cycle (controller wait, code Default) presents target on `iram_addr_o`; target instruction valid on `if_inst_o` the cycle after. `ctrl_iram_rdata_sel_i`=1 across both cycles squashes the stale fetch.
- Stall and Branch are mutually exclusive by encoding. Squash select overrides HOLD output but does not clear `hold_q`.

## Configuration
- `PC_FETCH_PERF_EN` defined: `perf_fetch_cnt_o` increments on every cycle with `if_valid_o`=1 and code Default (32b wrap). `perf_redirect_cnt_o` increments on each accepted Branch (16b wrap).
- Undefined: counter ports and logic are absent. Functional behaviour is otherwise identical.

## Test plan
- Reset, then 4 Default cycles -> `iram_addr_o` 0,4,8,C,10. `if_valid_o` rises on the 2nd cycle with `if_pc_o`=0 and inst = IRAM[0].
- Stall 3 cycles while `if_pc_o`=8 -> `if_pc_o`=8 and inst = IRAM[8] held throughout. Release -> IRAM[8] once, then IRAM[C]; no duplicate or skip.
- Branch target 32'h0000_0102 with rdata_sel=1 for 2 cycles -> `iram_addr_o`=0x100 in the cycle after Branch. Output NOP/invalid for 2 cycles, then `if_pc_o`=0x100 valid.
- `RESET_PC`=32'hFFFF_FFF8, Default run -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `rst`=0 asserted during HOLD with a Branch applied -> next cycle all reset values; Branch ignored. With `PC_FETCH_PERF_EN`, counters read 0.
- Bubble code on `ctrl_signal_pc_i` for 1 cycle -> behaves as a 1-cycle stall.
